alu_mul_sequencer: RTL and testbench
====================================

# alu_mul_sequencer

Multi-cycle controller that computes a 16-bit unsigned multiply (low 16 bits of the product) by sequencing the shared 16-bit ALU through shift-add iterations. It owns the ALU's operand and control inputs: it drives x/y and the six control bits, and captures the ALU output into internal registers. It sits beside the ALU in the CPU datapath and gives the instruction path a start/done multiply service without a dedicated multiplier.

## Interface
Parameters:
- None. Width is fixed at 16; the iteration count is fixed at 16.

Ports:
- clk  input  1  single clock; all registers update on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  request; sampled only in IDLE.
- op_a  input  16  multiplicand; captured on the accepted start edge.
- op_b  input  16  multiplier; captured on the accepted start edge.
- busy  output  1  high in ADD, DBL and DONE.
- done  output  1  one-cycle pulse; high only in DONE.
- product  output  16  registered result (op_a*op_b) mod 2^16; held until the next accepted start.
- alu_x  output  16  ALU first operand.
- alu_y  output  16  ALU second operand.
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  ALU control word.
- alu_out  input  16  combinational ALU result, sampled in the same cycle the operands are driven.

## Operation
- Internal registers: A (16 bits), B (16 bits), P (16 bits, drives product), cnt (4 bits), state.
- The control word is always the ADD code: zx=0, nx=0, zy=0, ny=0, f=1, no=0, so alu_out = x+y mod 2^16. There is no carry-out.
- States: IDLE, ADD, DBL, DONE.
- IDLE: alu_x=alu_y=0. If start=1 at an edge: A<=op_a, B<=op_b, P<=0, cnt<=0, and the next state is ADD.
- ADD: alu_x=P, alu_y=A. At the edge, if B[0]=1 then P<=alu_out; otherwise P holds. The next state is DBL.
- DBL: alu_x=A, alu_y=A. At the edge: A<=alu_out (doubling), B<=B>>1, cnt<=cnt+1. If cnt was 15, the next state is DONE; otherwise it is ADD.
- DONE: alu_x=alu_y=0, done=1. The next state is IDLE unconditionally.
- There is no early exit on B==0, so latency is fixed.
- start is ignored while busy=1, including in DONE.
- Changes to op_a or op_b after the accepted start have no effect.
- Bits of A that overflow past bit 15 are discarded, and P wraps mod 2^16.

## Timing
- Reset values: state=IDLE, busy=0, done=0, product=0, A=B=0, cnt=0, alu_x=alu_y=0, control word = ADD code.
- Reset takes effect immediately, without waiting for a clock edge. Asserting reset mid-operation aborts the multiply with no done pulse and clears product to 0.
- Take the start acceptance edge as edge k. The state after edge k+2i is ADDi and after edge k+2i+1 is DBLi, for i = 0..15.
- DONE holds in the cycle following edge k+32. done and busy fall after edge k+33.
- Latency from the start edge to the done cycle is 32 cycles; throughput is one multiply per 34 cycles.
- product takes its final value at edge k+31 (the ADD15 edge) and is stable while done=1.
- Back-to-back operation: start held high continuously is accepted at edge k+34, the first IDLE edge.
- alu_x and alu_y are combinational from state and registers. alu_out must settle within the same cycle.

## Test plan
- op_a=3, op_b=5, one-cycle start pulse -> done pulses exactly 32 cycles after the start edge; product=15; busy is high for 33 cycles; the control word stays 0,0,0,0,1,0 throughout.
- op_a=0xFFFF, op_b=0xFFFF -> product=0x0001. Separately, op_a=0x0100, op_b=0x0100 -> product=0x0000 (wrap).
- op_a=0x1234, op_b=0 -> product=0 and the done timing is unchanged. Then op_a=0, op_b=0xFFFF -> product=0.
- Start 7*9; while busy, pulse start with op_a=2, op_b=2 and change op_a/op_b -> the second start is ignored; product=63 with one done pulse only.
- Start 100*200; assert reset asynchronously mid-cycle 10 after the start -> busy, done and product go to 0 immediately; no done pulse follows. After release, 6*7 -> product=42.
- Hold start high with op_a=11, op_b=13, then op_a=2, op_b=3 -> two done pulses 34 cycles apart; product=143 in the first DONE and 6 in the second.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_mul_sequencer: 16x16 (mod 2^16) shift-add multiply on a shared ALU     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_mul_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DBL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] p_q, p_d;
  logic [3:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      p_q     <= 16'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          p_d     = 16'd0;
          cnt_d   = 4'd0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (b_q[0]) p_d = alu_out;
        state_d = S_DBL;
      end
      S_DBL: begin
        // Doubling goes through the ALU as A+A; overflow past bit 15 drops out.
        a_d     = alu_out;
        b_d     = {1'b0, b_q[15:1]};
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'd15) ? S_DONE : S_ADD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    alu_x = 16'd0;
    alu_y = 16'd0;
    case (state_q)
      S_ADD: begin
        busy  = 1'b1;
        alu_x = p_q;
        alu_y = a_q;
      end
      S_DBL: begin
        busy  = 1'b1;
        alu_x = a_q;
        alu_y = a_q;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // The ALU is only ever asked to add.
  assign alu_zx  = 1'b0;
  assign alu_nx  = 1'b0;
  assign alu_zy  = 1'b0;
  assign alu_ny  = 1'b0;
  assign alu_f   = 1'b1;
  assign alu_no  = 1'b0;
  assign product = p_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_mul_sequencer: scoreboard bench with a behavioural Hack-style ALU   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_mul_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] op_a, op_b;
  logic        busy, done;
  logic [15:0] product, alu_x, alu_y, alu_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;

  alu_mul_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out)
  );

  // Full ALU model so that a wrong control word corrupts the result.
  logic [15:0] x_z, x_n, y_z, y_n, f_o;
  assign x_z     = alu_zx ? 16'd0 : alu_x;
  assign x_n     = alu_nx ? ~x_z : x_z;
  assign y_z     = alu_zy ? 16'd0 : alu_y;
  assign y_n     = alu_ny ? ~y_z : y_z;
  assign f_o     = alu_f ? (x_n + y_n) : (x_n & y_n);
  assign alu_out = alu_no ? ~f_o : f_o;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_count = 0;
  int last_done_cyc = 0;
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: control word every cycle, scoreboard pop on each done pulse.
  always @(posedge clk) begin
    cyc++;
    #1;
    check_eq("ctrl_word", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'b000010);
    if (done) begin
      done_count++;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) check_eq("unexpected_done", 32'd1, 32'd0);
      else check_eq("product", {16'd0, product}, {16'd0, exp_q.pop_front()});
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    exp_q.push_back(16'(a * b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done from a negedge; exp_lat is the number of edges still to go.
  task automatic wait_done(input int exp_lat, input bit poke_in_done, input string tag);
    int n;
    int nb;
    n  = 0;
    nb = 0;
    while (n < 40) begin
      if (busy) nb++;
      if (done) break;
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_latency"}, n, exp_lat);
    check_eq({tag, "_busy_cycles"}, nb, exp_lat + 1);
    if (poke_in_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done_after"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int c1;
    int dc;
    reset = 1'b1;
    start = 1'b0;
    op_a  = 16'd0;
    op_b  = 16'd0;
    #12;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_product", {16'd0, product}, 32'd0);
    check_eq("rst_alu_xy", {alu_x, alu_y}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    issue(16'd3, 16'd5);           wait_done(32, 1'b0, "m3x5");
    issue(16'hFFFF, 16'hFFFF);     wait_done(32, 1'b0, "mffff");
    issue(16'h0100, 16'h0100);     wait_done(32, 1'b0, "wrap");
    issue(16'h1234, 16'h0000);     wait_done(32, 1'b0, "bzero");
    issue(16'h0000, 16'hFFFF);     wait_done(32, 1'b0, "azero");
    for (int i = 0; i < 3; i++) begin
      issue(16'($urandom), 16'($urandom));
      wait_done(32, 1'b0, "rand");
    end

    // Start while busy, operand changes, and start in DONE are all ignored.
    dc = done_count;
    issue(16'd7, 16'd9);
    repeat (5) @(negedge clk);
    start = 1'b1; op_a = 16'd2; op_b = 16'd2;
    @(negedge clk);
    start = 1'b0; op_a = 16'hFFFF; op_b = 16'h1234;
    wait_done(26, 1'b1, "ignore");
    repeat (40) @(negedge clk);
    check_eq("ignore_done_count", done_count - dc, 32'd1);

    // Asynchronous reset mid-operation.
    issue(16'd100, 16'd200);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_done", {31'd0, done}, 32'd0);
    check_eq("arst_product", {16'd0, product}, 32'd0);
    exp_q.delete();
    dc = done_count;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("arst_no_done", done_count - dc, 32'd0);
    issue(16'd6, 16'd7);           wait_done(32, 1'b0, "after_rst");

    // Back-to-back with start held high.
    @(negedge clk);
    op_a = 16'd11; op_b = 16'd13; start = 1'b1;
    exp_q.push_back(16'd143);
    @(negedge clk);
    op_a = 16'd2; op_b = 16'd3;
    exp_q.push_back(16'd6);
    wait_done(32, 1'b0, "b2b_first");
    c1 = last_done_cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(32, 1'b0, "b2b_second");
    check_eq("b2b_spacing", last_done_cyc - c1, 32'd34);
    check_eq("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
